// File: rtl/dm_stack_ctrl.sv
// Operand stack controller: maps push/pop/peek requests onto single-port data
// memory cycles, keeping the stack pointer and absorbing the 1-cycle read latency.
module dm_stack_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              peek,
    input  logic [DATA_W-1:0] push_data,
    output logic              ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_dw_or_dr,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDW
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic                r_ready;
    logic                r_rdValid;
    logic [DATA_W-1:0]   r_rdData;
    logic                r_err;
    logic [DATA_W-1:0]   r_memDin;
    logic [ADDR_W-1:0]   r_memAddr;
    logic                r_memDw;
    logic                r_incOnWr;
    logic                r_isPop;

    logic                w_full;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_nextAddr;
    logic [ADDR_W-1:0]   w_topAddr;

    assign w_full     = (r_count == LIMIT);
    assign w_empty    = (r_count == '0);
    assign w_nextAddr = BASE + ADDR_W'(r_count);
    assign w_topAddr  = w_nextAddr - ADDR_W'(1);

    // Memory-side outputs are all registered; reset clears the write strobe
    // asynchronously so a write in flight is abandoned before its commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_ready   <= 1'b1;
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
            r_err     <= 1'b0;
            r_memDin  <= '0;
            r_memAddr <= BASE;
            r_memDw   <= 1'b0;
            r_incOnWr <= 1'b0;
            r_isPop   <= 1'b0;
        end else begin
            r_err     <= 1'b0;
            r_rdValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (push && pop && !w_empty) begin
                        // Replace-top: overwrite the top entry, depth unchanged
                        r_state   <= S_WR;
                        r_ready   <= 1'b0;
                        r_memAddr <= w_topAddr;
                        r_memDin  <= push_data;
                        r_memDw   <= 1'b1;
                        r_incOnWr <= 1'b0;
                    end else if (push) begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state   <= S_WR;
                            r_ready   <= 1'b0;
                            r_memAddr <= w_nextAddr;
                            r_memDin  <= push_data;
                            r_memDw   <= 1'b1;
                            r_incOnWr <= 1'b1;
                        end
                    end else if (pop || peek) begin
                        if (w_empty) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state   <= S_RD;
                            r_ready   <= 1'b0;
                            r_memAddr <= w_topAddr;
                            r_memDw   <= 1'b0;
                            r_isPop   <= pop;
                        end
                    end
                end
                S_WR: begin
                    r_memDw <= 1'b0;
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    if (r_incOnWr) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_RD: begin
                    r_state <= S_RDW;
                end
                S_RDW: begin
                    // Memory registered Dout on the previous edge
                    r_rdData  <= mem_dout;
                    r_rdValid <= 1'b1;
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b1;
                    if (r_isPop) begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_memDw <= 1'b0;
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign rd_valid     = r_rdValid;
    assign rd_data      = r_rdData;
    assign err          = r_err;
    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign mem_din      = r_memDin;
    assign mem_addr     = r_memAddr;
    assign mem_dw_or_dr = r_memDw;

endmodule

// File: tb/tb_dm_stack_ctrl.sv
// Directed bench for dm_stack_ctrl: instance A (DEPTH=64, base 0) and
// instance B (DEPTH=4, base 0x0100), each attached to a small registered-read memory.
module tb_dm_stack_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        pushA = 1'b0, popA = 1'b0, peekA = 1'b0;
    logic [15:0] dataA = '0;
    logic        readyA, rdValidA, errA, fullA, emptyA, dwA;
    logic [15:0] rdDataA, dinA, addrA;
    logic [15:0] doutA = '0;
    logic [6:0]  countA;

    logic        pushB = 1'b0, popB = 1'b0, peekB = 1'b0;
    logic [15:0] dataB = '0;
    logic        readyB, rdValidB, errB, fullB, emptyB, dwB;
    logic [15:0] rdDataB, dinB, addrB;
    logic [15:0] doutB = '0;
    logic [2:0]  countB;

    logic [15:0] memA [64];
    logic [15:0] memB [4];
    int wrCountA = 0;
    int wrCountB = 0;
    int rdValidCountA = 0;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    dm_stack_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .BASE_ADDR(0)) dutA (
        .clk(clk), .rst(rst), .push(pushA), .pop(popA), .peek(peekA), .push_data(dataA),
        .ready(readyA), .rd_valid(rdValidA), .rd_data(rdDataA), .err(errA),
        .full(fullA), .empty(emptyA), .count(countA),
        .mem_din(dinA), .mem_addr(addrA), .mem_dw_or_dr(dwA), .mem_dout(doutA)
    );

    dm_stack_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .BASE_ADDR(16'h0100)) dutB (
        .clk(clk), .rst(rst), .push(pushB), .pop(popB), .peek(peekB), .push_data(dataB),
        .ready(readyB), .rd_valid(rdValidB), .rd_data(rdDataB), .err(errB),
        .full(fullB), .empty(emptyB), .count(countB),
        .mem_din(dinB), .mem_addr(addrB), .mem_dw_or_dr(dwB), .mem_dout(doutB)
    );

    // Data memories: write on DW_or_DR=1, registered read of the addressed word
    always @(posedge clk) begin
        if (dwA) begin
            memA[addrA[5:0]] <= dinA;
            wrCountA <= wrCountA + 1;
        end
        doutA <= memA[addrA[5:0]];
        if (dwB) begin
            memB[addrB[1:0]] <= dinB;
            wrCountB <= wrCountB + 1;
        end
        doutB <= memB[addrB[1:0]];
        if (rdValidA) rdValidCountA <= rdValidCountA + 1;
    end

    // Drivers return 1 time unit after the accept edge
    task automatic reqA(input logic pu, input logic po, input logic pk, input logic [15:0] d);
        @(negedge clk);
        pushA = pu; popA = po; peekA = pk; dataA = d;
        @(posedge clk);
        #1;
        pushA = 1'b0; popA = 1'b0; peekA = 1'b0;
    endtask

    task automatic reqB(input logic pu, input logic po, input logic pk, input logic [15:0] d);
        @(negedge clk);
        pushB = pu; popB = po; peekB = pk; dataB = d;
        @(posedge clk);
        #1;
        pushB = 1'b0; popB = 1'b0; peekB = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({readyA, rdValidA, errA, dwA, emptyA, fullA} !== 6'b100010) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags got %b want 100010", {readyA, rdValidA, errA, dwA, emptyA, fullA});
        end
        nCompared++;
        if ({countA, rdDataA, addrA, dinA} !== {7'd0, 48'h0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_values got cnt=%0d rd=%h addr=%h din=%h want all 0", countA, rdDataA, addrA, dinA);
        end
        nCompared++;
        if (addrB !== 16'h0100) begin
            nMismatched++;
            $display("[TB] FAIL reset_addrB got %h want 0100", addrB);
        end
    endtask

    task automatic test_push();
        logic [15:0] vals [3];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
        for (int i = 0; i < 3; i++) begin
            reqA(1'b1, 1'b0, 1'b0, vals[i]);
            nCompared++;
            if ({dwA, readyA, addrA, dinA} !== {2'b10, 16'(i), vals[i]}) begin
                nMismatched++;
                $display("[TB] FAIL push_wr%0d got dw=%b rdy=%b addr=%h din=%h want dw=1 rdy=0 addr=%h din=%h",
                         i, dwA, readyA, addrA, dinA, 16'(i), vals[i]);
            end
            @(posedge clk);
            #1;
            nCompared++;
            if ({dwA, readyA, errA, countA} !== {3'b010, 7'(i + 1)}) begin
                nMismatched++;
                $display("[TB] FAIL push_done%0d got dw=%b rdy=%b err=%b cnt=%0d want 0 1 0 %0d",
                         i, dwA, readyA, errA, countA, i + 1);
            end
        end
        nCompared++;
        if ({emptyA, memA[0], memA[1], memA[2]} !== {1'b0, 48'h0011_0022_0033}) begin
            nMismatched++;
            $display("[TB] FAIL push_mem got empty=%b mem=%h %h %h want 0 0011 0022 0033", emptyA, memA[0], memA[1], memA[2]);
        end
    endtask

    task automatic test_pop();
        logic [15:0] exp [3];
        int wrBefore;
        exp[0] = 16'h0033; exp[1] = 16'h0022; exp[2] = 16'h0011;
        for (int i = 0; i < 3; i++) begin
            reqA(1'b0, 1'b1, 1'b0, 16'h0);
            nCompared++;
            if ({dwA, readyA, addrA} !== {2'b00, 16'(2 - i)}) begin
                nMismatched++;
                $display("[TB] FAIL pop_rd%0d got dw=%b rdy=%b addr=%h want 0 0 %h", i, dwA, readyA, addrA, 16'(2 - i));
            end
            @(posedge clk);
            #1;
            nCompared++;
            if (rdValidA !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL pop_early%0d got rd_valid=%b want 0", i, rdValidA);
            end
            @(posedge clk);
            #1;
            nCompared++;
            if ({rdValidA, readyA, rdDataA, countA} !== {2'b11, exp[i], 7'(2 - i)}) begin
                nMismatched++;
                $display("[TB] FAIL pop_data%0d got v=%b rdy=%b data=%h cnt=%0d want 1 1 %h %0d",
                         i, rdValidA, readyA, rdDataA, countA, exp[i], 2 - i);
            end
        end
        wrBefore = wrCountA;
        reqA(1'b0, 1'b1, 1'b0, 16'h0);
        nCompared++;
        if ({errA, readyA, dwA, countA} !== {3'b110, 7'd0}) begin
            nMismatched++;
            $display("[TB] FAIL underflow got err=%b rdy=%b dw=%b cnt=%0d want 1 1 0 0", errA, readyA, dwA, countA);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if ({errA, rdValidA, emptyA} !== 3'b001 || wrCountA != wrBefore) begin
            nMismatched++;
            $display("[TB] FAIL underflow_after got err=%b v=%b empty=%b writes=%0d want 0 0 1 %0d",
                     errA, rdValidA, emptyA, wrCountA, wrBefore);
        end
    endtask

    task automatic test_full_and_base();
        logic [15:0] vals [4];
        int wrBefore;
        vals[0] = 16'hBEEF; vals[1] = 16'h00A2; vals[2] = 16'h00A3; vals[3] = 16'h00A4;
        for (int i = 0; i < 4; i++) begin
            reqB(1'b1, 1'b0, 1'b0, vals[i]);
            nCompared++;
            if ({dwB, addrB, dinB} !== {1'b1, 16'h0100 + 16'(i), vals[i]}) begin
                nMismatched++;
                $display("[TB] FAIL base_wr%0d got dw=%b addr=%h din=%h want 1 %h %h",
                         i, dwB, addrB, dinB, 16'h0100 + 16'(i), vals[i]);
            end
            @(posedge clk);
            #1;
            nCompared++;
            if ({dwB, readyB, countB} !== {2'b01, 3'(i + 1)}) begin
                nMismatched++;
                $display("[TB] FAIL base_done%0d got dw=%b rdy=%b cnt=%0d want 0 1 %0d", i, dwB, readyB, countB, i + 1);
            end
        end
        nCompared++;
        if (fullB !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL full_flag got %b want 1", fullB);
        end
        wrBefore = wrCountB;
        reqB(1'b1, 1'b0, 1'b0, 16'h00A5);
        nCompared++;
        if ({errB, dwB, readyB, countB} !== {3'b101, 3'd4}) begin
            nMismatched++;
            $display("[TB] FAIL overflow got err=%b dw=%b rdy=%b cnt=%0d want 1 0 1 4", errB, dwB, readyB, countB);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (errB !== 1'b0 || dwB !== 1'b0 || wrCountB != wrBefore) begin
            nMismatched++;
            $display("[TB] FAIL overflow_after got err=%b dw=%b writes=%0d want 0 0 %0d", errB, dwB, wrCountB, wrBefore);
        end
        reqB(1'b0, 1'b0, 1'b1, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if ({rdValidB, rdDataB, countB, fullB} !== {1'b1, 16'h00A4, 3'd4, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL peek_full got v=%b data=%h cnt=%0d full=%b want 1 00a4 4 1", rdValidB, rdDataB, countB, fullB);
        end
    endtask

    task automatic test_replace_top();
        // push&pop on an empty stack behaves as a plain push
        reqA(1'b1, 1'b1, 1'b0, 16'h0005);
        @(posedge clk);
        #1;
        nCompared++;
        if ({countA, memA[0]} !== {7'd1, 16'h0005}) begin
            nMismatched++;
            $display("[TB] FAIL pushpop_empty got cnt=%0d mem0=%h want 1 0005", countA, memA[0]);
        end
        reqA(1'b1, 1'b0, 1'b0, 16'h0007);
        @(posedge clk);
        reqA(1'b1, 1'b1, 1'b0, 16'h000C);
        nCompared++;
        if ({dwA, addrA, dinA} !== {1'b1, 16'h0001, 16'h000C}) begin
            nMismatched++;
            $display("[TB] FAIL replace_wr got dw=%b addr=%h din=%h want 1 0001 000c", dwA, addrA, dinA);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if ({countA, memA[1], readyA} !== {7'd2, 16'h000C, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL replace_done got cnt=%0d mem1=%h rdy=%b want 2 000c 1", countA, memA[1], readyA);
        end
        reqA(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if ({rdValidA, rdDataA, countA} !== {1'b1, 16'h000C, 7'd1}) begin
            nMismatched++;
            $display("[TB] FAIL replace_pop got v=%b data=%h cnt=%0d want 1 000c 1", rdValidA, rdDataA, countA);
        end
        reqA(1'b0, 1'b0, 1'b1, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if ({rdValidA, rdDataA, countA} !== {1'b1, 16'h0005, 7'd1}) begin
            nMismatched++;
            $display("[TB] FAIL peek got v=%b data=%h cnt=%0d want 1 0005 1", rdValidA, rdDataA, countA);
        end
    endtask

    task automatic test_reset_midop();
        int validBefore;
        // Write targeting address 1 (currently 0x000C) abandoned by reset
        reqA(1'b1, 1'b0, 1'b0, 16'h0099);
        #2;
        rst = 1'b1;
        #1;
        nCompared++;
        if (dwA !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rst_wr_async got dw=%b want 0", dwA);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({memA[1], countA, readyA} !== {16'h000C, 7'd0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL rst_wr got mem1=%h cnt=%0d rdy=%b want 000c 0 1", memA[1], countA, readyA);
        end
        reqA(1'b1, 1'b0, 1'b0, 16'h0055);
        @(posedge clk);
        validBefore = rdValidCountA;
        reqA(1'b0, 1'b1, 1'b0, 16'h0);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if ({memA[0], countA, readyA, rdValidA} !== {16'h0055, 7'd0, 2'b10} || rdValidCountA != validBefore) begin
            nMismatched++;
            $display("[TB] FAIL rst_rd got mem0=%h cnt=%0d rdy=%b v=%b pulses=%0d want 0055 0 1 0 %0d",
                     memA[0], countA, readyA, rdValidA, rdValidCountA, validBefore);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) memA[i] = '0;
        for (int i = 0; i < 4; i++) memB[i] = '0;
        test_reset();
        test_push();
        test_pop();
        test_full_and_base();
        test_replace_top();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
